datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
Sequencing controller that drives the existing `datapath` register file and ULA from a stream of encoded instructions. It accepts one instruction per valid/ready handshake and decodes it. It then steps the datapath through read/execute and write-back. It returns the ULA result and flags on a valid/ready response channel. It sits between an upstream instruction source and the `datapath` instance, and owns every datapath control input.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears state on next rising edge)
in_valid  input  1  instruction offered
in_ready  output  1  controller can accept an instruction
in_instr  input  21  [20]=use_imm, [19:17]=op, [16:14]=rd, [13:11]=rs1, [10:8]=rs2, [7:0]=imm
out_valid  output  1  response available
out_ready  input  1  consumer accepts response
out_result  output  8  ULA result, or the loaded immediate
out_carry  output  1  captured CarryOut
out_zero  output  1  captured Flag_z (immediate==0 for LOADI)
out_err  output  1  illegal opcode
dp_wd3  output  8  datapath write data
dp_wa3  output  3  datapath write address
dp_we3  output  1  datapath write enable
dp_ra1  output  3  datapath read address A
dp_ra2  output  3  datapath read address B
dp_constante  output  8  datapath constant operand
dp_select_src  output  1  datapath SrcB select (0=register rd2, 1=constante)
dp_ULAControl  output  3  datapath ULA operation
dp_ULAResult  input  8  datapath result
dp_CarryOut  input  1  datapath carry
dp_Flag_z  input  1  datapath zero flag
retired_count  output  CNT_W  saturating count of completed responses

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (unsigned, result 1/0), 100 LOADI, 110/111 illegal.
- FSM states: IDLE, EXEC, WB, RESP.
- IDLE: in_ready=1. On in_valid, latch in_instr into the decode register.
  - Next state EXEC for ULA ops, WB for LOADI, RESP with err=1 for illegal ops.
- EXEC (1 cycle), driven from the latched fields:
  - dp_ra1=rs1, dp_ra2=rs2, dp_select_src=use_imm, dp_constante=imm, dp_ULAControl=op.
  - Register dp_ULAResult/dp_CarryOut/dp_Flag_z at the end of the cycle. Next state WB.
- WB (1 cycle): dp_we3=1, dp_wa3=rd.
  - dp_wd3 = captured result for ULA ops, imm for LOADI.
  - LOADI captures result=imm, carry=0, zero=(imm==0). Next state RESP.
- RESP: out_valid=1 with result/flags/err stable until out_ready. Then retired_count += 1 (saturates at all-ones) and go to IDLE.
- Latency, accept edge to out_valid: 3 cycles for ULA ops, 2 for LOADI, 1 for illegal.
- Throughput: one instruction per (latency+1) cycles with out_ready=1 (plus stall cycles under backpressure).
- in_ready is high only in IDLE: no instruction overlap, no skid buffer.
- dp_we3 is high for exactly one cycle per ULA/LOADI instruction and never for illegal ops.
- Outside their active state, datapath control outputs are 0: dp_we3, dp_select_src, dp_ULAControl, addresses, data.
- All 8 registers are writable, including rd=0.
- rd equal to rs1/rs2 is legal: the read completes in EXEC before the WB write.
- Reset (reset==0 at an edge), from any state including mid-instruction:
  - State←IDLE, pending instruction dropped, no write issued.
  - All outputs 0 except in_ready=1; retired_count=0.
  - Reset takes priority over any handshake in the same cycle.
- out_valid && !out_ready holds every response field unchanged.

Decomposition:
- Package `datapath_pkg`:
  - Enum `ula_op_t` (ADD=000, SUB=001, AND=010, OR=011, LOADI=100, SLT=101).
  - Packed struct `instr_t` matching the in_instr layout.
  - Enum `ctrl_state_t` (IDLE, EXEC, WB, RESP).
- A combinational sub-module `instr_decode` maps `instr_t` to is_ula/is_loadi/is_illegal; the rest lives in `datapath_ctrl`.

Test Plan:
- LOADI r1,5 then LOADI r2,3 -> WB writes 5 to wa3=1 and 3 to wa3=2. Responses 5 and 3, each out_valid 2 cycles after accept.
- ADD r3,r1,r2 (use_imm=0) after the loads -> out_result=8, carry=0, zero=0, out_valid 3 cycles after accept, one dp_we3 pulse with wa3=3, wd3=8.
- ADD r4,r1,imm=0xFB (use_imm=1) -> dp_select_src=1 in EXEC, dp_constante=0xFB. out_result=0x00, carry=1, zero=1.
- SLT r5,r1,r2 (5<3) -> result 0. SLT r5,r2,r1 -> result 1. AND r1,r2 -> 1. OR r1,r2 -> 7.
- op=110 -> out_err=1 one cycle after accept, dp_we3 never asserted, register contents unchanged (re-read via ADD rX, imm 0).
- Hold out_ready=0 for 5 cycles during RESP -> out_* stable, in_ready=0. Pulse reset=0 during EXEC of an ADD -> no write, next cycle state IDLE, in_ready=1, out_valid=0, retired_count=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the datapath sequencing controller: opcodes, instruction
// layout and controller states.
package datapath_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    LOADI = 3'b100,
    SLT   = 3'b101
  } ula_op_t;

  // op is kept as raw bits so the reserved encodings 110/111 stay representable
  typedef struct packed {
    logic       use_imm;
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/datapath_ctrl_instr_decode.sv
// Opcode classifier: splits an instruction into ULA op, immediate load or
// illegal encoding.
module instr_decode
  import datapath_pkg::*;
(
  input  instr_t i_instr,
  output logic   o_is_ula,
  output logic   o_is_loadi,
  output logic   o_is_illegal
);

  always_comb begin
    o_is_ula     = 1'b0;
    o_is_loadi   = 1'b0;
    o_is_illegal = 1'b0;
    case (i_instr.op)
      ADD, SUB, AND, OR, SLT: o_is_ula   = 1'b1;
      LOADI:                  o_is_loadi = 1'b1;
      default:                o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Sequences the datapath register file and ULA through execute and write-back
// for one handshaked instruction at a time, returning result and flags.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [20:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [7:0]       dp_wd3,
  output logic [2:0]       dp_wa3,
  output logic             dp_we3,
  output logic [2:0]       dp_ra1,
  output logic [2:0]       dp_ra2,
  output logic [7:0]       dp_constante,
  output logic             dp_select_src,
  output logic [2:0]       dp_ULAControl,
  input  logic [7:0]       dp_ULAResult,
  input  logic             dp_CarryOut,
  input  logic             dp_Flag_z,
  output logic [CNT_W-1:0] retired_count
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next_state;
  instr_t           r_instr;
  logic [7:0]       r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;
  logic [CNT_W-1:0] r_retired;

  instr_t w_in_instr;
  instr_t w_dec_src;
  logic   w_is_ula;
  logic   w_is_loadi;
  logic   w_is_illegal;

  assign w_in_instr = in_instr;
  // Decode the incoming word while idle, the latched word afterwards
  assign w_dec_src  = (r_state == IDLE) ? w_in_instr : r_instr;

  instr_decode u_decode (
    .i_instr      (w_dec_src),
    .o_is_ula     (w_is_ula),
    .o_is_loadi   (w_is_loadi),
    .o_is_illegal (w_is_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (in_valid) begin
          r_instr  <= w_in_instr;
          r_err    <= w_is_illegal;
          r_result <= '0;
          r_carry  <= 1'b0;
          r_zero   <= 1'b0;
        end
        EXEC: begin
          r_result <= dp_ULAResult;
          r_carry  <= dp_CarryOut;
          r_zero   <= dp_Flag_z;
        end
        WB: if (w_is_loadi) begin
          r_result <= r_instr.imm;
          r_carry  <= 1'b0;
          r_zero   <= (r_instr.imm == 8'd0);
        end
        RESP: if (out_ready && (r_retired != '1)) begin
          r_retired <= r_retired + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_result    = '0;
    out_carry     = 1'b0;
    out_zero      = 1'b0;
    out_err       = 1'b0;
    dp_wd3        = '0;
    dp_wa3        = '0;
    dp_we3        = 1'b0;
    dp_ra1        = '0;
    dp_ra2        = '0;
    dp_constante  = '0;
    dp_select_src = 1'b0;
    dp_ULAControl = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_is_ula)        w_next_state = EXEC;
          else if (w_is_loadi) w_next_state = WB;
          else                 w_next_state = RESP;
        end
      end
      EXEC: begin
        dp_ra1        = r_instr.rs1;
        dp_ra2        = r_instr.rs2;
        dp_select_src = r_instr.use_imm;
        dp_constante  = r_instr.imm;
        dp_ULAControl = r_instr.op;
        w_next_state  = WB;
      end
      WB: begin
        dp_we3       = 1'b1;
        dp_wa3       = r_instr.rd;
        dp_wd3       = w_is_loadi ? r_instr.imm : r_result;
        w_next_state = RESP;
      end
      RESP: begin
        out_valid  = 1'b1;
        out_result = r_result;
        out_carry  = r_carry;
        out_zero   = r_zero;
        out_err    = r_err;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign retired_count = r_retired;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a behavioural register file and ULA
// standing in for the datapath instance.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_err;
  logic [7:0]  dp_wd3;
  logic [2:0]  dp_wa3;
  logic        dp_we3;
  logic [2:0]  dp_ra1;
  logic [2:0]  dp_ra2;
  logic [7:0]  dp_constante;
  logic        dp_select_src;
  logic [2:0]  dp_ULAControl;
  logic [7:0]  dp_ULAResult;
  logic        dp_CarryOut;
  logic        dp_Flag_z;
  logic [15:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int exp_ret  = 0;
  logic [2:0] last_wa;
  logic [7:0] last_wd;
  logic       sel;
  logic [7:0] cst;

  always #5 clk = ~clk;

  datapath_ctrl #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_carry     (out_carry),
    .out_zero      (out_zero),
    .out_err       (out_err),
    .dp_wd3        (dp_wd3),
    .dp_wa3        (dp_wa3),
    .dp_we3        (dp_we3),
    .dp_ra1        (dp_ra1),
    .dp_ra2        (dp_ra2),
    .dp_constante  (dp_constante),
    .dp_select_src (dp_select_src),
    .dp_ULAControl (dp_ULAControl),
    .dp_ULAResult  (dp_ULAResult),
    .dp_CarryOut   (dp_CarryOut),
    .dp_Flag_z     (dp_Flag_z),
    .retired_count (retired_count)
  );

  // Datapath stand-in: 8x8 register file, unsigned ULA
  logic [7:0] rf [8];
  always @(posedge clk) if (dp_we3) rf[dp_wa3] <= dp_wd3;

  always_comb begin
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] t;
    a = rf[dp_ra1];
    b = dp_select_src ? dp_constante : rf[dp_ra2];
    t = '0;
    case (dp_ULAControl)
      3'b000:  t = {1'b0, a} + {1'b0, b};
      3'b001:  t = {1'b0, a} - {1'b0, b};
      3'b010:  t = {1'b0, a & b};
      3'b011:  t = {1'b0, a | b};
      3'b101:  t = (a < b) ? 9'd1 : 9'd0;
      default: t = '0;
    endcase
    dp_ULAResult = t[7:0];
    dp_CarryOut  = t[8];
    dp_Flag_z    = (t[7:0] == 8'd0);
  end

  always @(negedge clk) begin
    if (dp_we3) begin
      we_cnt  = we_cnt + 1;
      last_wa = dp_wa3;
      last_wd = dp_wd3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic ui, input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm);
    return {ui, op, rd, rs1, rs2, imm};
  endfunction

  task automatic do_instr(input string tag, input logic [20:0] instr, input int exp_lat,
                          input logic [7:0] exp_res, input logic exp_c, input logic exp_z,
                          input logic exp_err, input int stall,
                          output logic o_sel, output logic [7:0] o_cst);
    int lat;
    int we0;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    we0       = we_cnt;
    in_valid  = 1'b1;
    in_instr  = instr;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = '0;
    lat   = 1;
    o_sel = 1'b0;
    o_cst = '0;
    forever begin
      @(negedge clk);
      if (lat == 1) begin
        o_sel = dp_select_src;
        o_cst = dp_constante;
      end
      if (out_valid || lat > 8) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, 32'(out_result), 32'(exp_res));
    chk({tag, " carry"}, 32'(out_carry), 32'(exp_c));
    chk({tag, " zero"}, 32'(out_zero), 32'(exp_z));
    chk({tag, " err"}, 32'(out_err), 32'(exp_err));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(out_valid), 1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 0);
      chk({tag, " hold result"}, 32'(out_result), 32'(exp_res));
      chk({tag, " hold err"}, 32'(out_err), 32'(exp_err));
    end
    out_ready = 1'b1;
    @(posedge clk);
    exp_ret++;
    @(negedge clk);
    chk({tag, " out_valid drop"}, 32'(out_valid), 0);
    chk({tag, " retired"}, 32'(retired_count), exp_ret);
    chk({tag, " we pulses"}, we_cnt - we0, exp_err ? 0 : 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int we0;
    for (int i = 0; i < 8; i++) rf[i] = 8'd0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst retired", 32'(retired_count), 0);
    chk("rst we3", 32'(dp_we3), 0);
    chk("rst result", 32'(out_result), 0);
    reset = 1'b1;

    do_instr("loadi r1", mk(0, 3'b100, 3'd1, 3'd0, 3'd0, 8'd5), 2, 8'd5, 0, 0, 0, 0, sel, cst);
    chk("loadi r1 wa3", 32'(last_wa), 1);
    chk("loadi r1 wd3", 32'(last_wd), 5);
    do_instr("loadi r2", mk(0, 3'b100, 3'd2, 3'd0, 3'd0, 8'd3), 2, 8'd3, 0, 0, 0, 0, sel, cst);
    chk("loadi r2 wa3", 32'(last_wa), 2);
    chk("loadi r2 wd3", 32'(last_wd), 3);

    do_instr("add r3", mk(0, 3'b000, 3'd3, 3'd1, 3'd2, 8'd0), 3, 8'd8, 0, 0, 0, 0, sel, cst);
    chk("add r3 wa3", 32'(last_wa), 3);
    chk("add r3 wd3", 32'(last_wd), 8);
    chk("add r3 sel", 32'(sel), 0);

    do_instr("add imm", mk(1, 3'b000, 3'd4, 3'd1, 3'd0, 8'hFB), 3, 8'h00, 1, 1, 0, 0, sel, cst);
    chk("add imm sel", 32'(sel), 1);
    chk("add imm const", 32'(cst), 32'hFB);

    do_instr("slt 5<3", mk(0, 3'b101, 3'd5, 3'd1, 3'd2, 8'd0), 3, 8'd0, 0, 1, 0, 0, sel, cst);
    do_instr("slt 3<5", mk(0, 3'b101, 3'd5, 3'd2, 3'd1, 8'd0), 3, 8'd1, 0, 0, 0, 0, sel, cst);
    do_instr("and", mk(0, 3'b010, 3'd6, 3'd1, 3'd2, 8'd0), 3, 8'd1, 0, 0, 0, 0, sel, cst);
    do_instr("or", mk(0, 3'b011, 3'd7, 3'd1, 3'd2, 8'd0), 3, 8'd7, 0, 0, 0, 0, sel, cst);
    do_instr("sub 5-3", mk(0, 3'b001, 3'd6, 3'd1, 3'd2, 8'd0), 3, 8'd2, 0, 0, 0, 0, sel, cst);
    do_instr("sub 3-5", mk(0, 3'b001, 3'd6, 3'd2, 3'd1, 8'd0), 3, 8'hFE, 1, 0, 0, 0, sel, cst);

    do_instr("illegal", mk(0, 3'b110, 3'd1, 3'd0, 3'd0, 8'h55), 1, 8'd0, 0, 0, 1, 0, sel, cst);
    do_instr("illegal7", mk(1, 3'b111, 3'd2, 3'd0, 3'd0, 8'hAA), 1, 8'd0, 0, 0, 1, 0, sel, cst);
    do_instr("reread r1", mk(1, 3'b000, 3'd0, 3'd1, 3'd0, 8'd0), 3, 8'd5, 0, 0, 0, 0, sel, cst);
    chk("reread r1 wa3", 32'(last_wa), 0);
    do_instr("r0 += 1", mk(1, 3'b000, 3'd0, 3'd0, 3'd0, 8'd1), 3, 8'd6, 0, 0, 0, 0, sel, cst);
    chk("r0 += 1 wd3", 32'(last_wd), 6);
    do_instr("loadi zero", mk(0, 3'b100, 3'd3, 3'd0, 3'd0, 8'd0), 2, 8'd0, 0, 1, 0, 0, sel, cst);

    do_instr("stall or", mk(0, 3'b011, 3'd7, 3'd1, 3'd2, 8'd0), 3, 8'd7, 0, 0, 0, 5, sel, cst);

    // Reset while the ADD is in EXEC must drop it without a write
    @(negedge clk);
    chk("rst-exec in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_instr = mk(1, 3'b000, 3'd1, 3'd1, 3'd0, 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = '0;
    @(negedge clk);
    chk("rst-exec in EXEC", 32'(dp_select_src), 1);
    we0   = we_cnt;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst-exec in_ready", 32'(in_ready), 1);
    chk("rst-exec out_valid", 32'(out_valid), 0);
    chk("rst-exec retired", 32'(retired_count), 0);
    chk("rst-exec we3", 32'(dp_we3), 0);
    @(negedge clk);
    chk("rst-exec no write", we_cnt - we0, 0);
    exp_ret = 0;
    do_instr("post-rst r1", mk(1, 3'b000, 3'd2, 3'd1, 3'd0, 8'd0), 3, 8'd5, 0, 0, 0, 0, sel, cst);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
